mux_arb_reg: RTL
================

// Module: mux_arb_reg
// PURPOSE
//  - Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshake.
//  - Two selection modes:
//    - FIXED: select-driven, the successor of the plain 4:1 datapath mux.
//    - RR: round-robin arbitration among the requesting channels.
//  - Sits between multiple producers and one consumer, e.g. write-back source merge or memory request merge.
//  - Output is registered: one transfer per cycle at full throughput.
// PARAMETERS
//  NCH    4                  number of input channels, >= 2
//  WIDTH  32                 data width per channel
//  SELW   $clog2(NCH)        select / channel-id width (derived, do not override)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  mode       in   1           0 = FIXED (use sel), 1 = RR (round-robin)
//  sel        in   SELW        channel index in FIXED mode; ignored in RR
//  in_valid   in   NCH         per-channel request; bit i = channel i
//  in_ready   out  NCH         per-channel accept; at most one bit high per cycle
//  in_data    in   NCH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  out_valid  out  1           output register holds valid data
//  out_ready  in   1           consumer accepts out_data this cycle
//  out_data   out  WIDTH       registered selected data
//  out_ch     out  SELW        index of the channel that produced out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
//  - in_ready is combinational. It is 0 on every bit while rst_n=0.
//  - can_load = !out_valid || out_ready. The output register loads whenever can_load=1.
//  - Grant (combinational):
//    - FIXED: gnt = sel if in_valid[sel]; otherwise no grant. Other channels always stall.
//      - sel >= NCH: no grant.
//    - RR: gnt = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., NCH-1, 0, ... (mod NCH).
//  - in_ready[gnt] = can_load && grant_exists. All other bits are 0.
//  - Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge:
//    - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
//    - RR mode only: ptr <= (g == NCH-1) ? 0 : g+1. FIXED mode never changes ptr.
//  - No transfer while can_load=1: out_valid <= 0; out_data and out_ch hold their values.
//  - can_load=0: out_valid, out_data and out_ch hold. No input is accepted.
//  - Latency: input accept to out_valid = 1 cycle.
//    - Throughput: 1 transfer per cycle when out_ready is held at 1.
//  - Simultaneous events: a consumer pop and a new load in the same cycle is a legal single-cycle handoff.
//  - A mode or sel change applies to the same cycle's grant (pure combinational).
//    - ptr is retained across mode changes.
//  - The output side is AXI-style: out_valid/out_data are stable until accepted.
//    - Inputs must likewise hold in_data while in_valid && !in_ready.
//  - Reset mid-transfer: the pending output is discarded. The upstream owner must re-present.
// STRUCTURE
//  - Package mux_arb_pkg:
//    - MODE_FIXED=1'b0, MODE_RR=1'b1.
//    - Function rr_next(idx, nch) for the pointer wrap.
//  - Sub-module rr_arbiter #(NCH) (req, ptr, mode, sel -> gnt_onehot, gnt_idx, gnt_vld).
//    - Purely combinational.
//    - Instantiated once; the top level holds ptr and the output register.
// TESTING
//  1. Reset: hold rst_n=0 with in_valid=4'hF.
//     -> in_ready=0, out_valid=0, out_data=0, out_ch=0.
//     Release, then one cycle later -> out_valid=1, out_ch=0.
//  2. FIXED: mode=0, sel=2, in_valid=4'hF, out_ready=1.
//     -> in_ready=4'b0100 every cycle, out_ch=2 stream.
//     Then in_valid[2]=0 -> in_ready=0, out_valid falls next cycle.
//  3. RR fairness: mode=1, in_valid=4'hF held 8 cycles, out_ready=1.
//     -> out_ch sequence 0,1,2,3,0,1,2,3; ptr wraps 3->0.
//  4. RR sparse: in_valid=4'b1010, starting from ptr=0.
//     -> out_ch 1,3,1,3.
//     Then in_valid=4'b0001 -> channel 0 is granted within 1 cycle.
//  5. Backpressure: stream active, then out_ready=0 for 3 cycles.
//     -> out_data and out_ch stable, in_ready=0.
//     Release -> same item popped, next item loaded in the same cycle, no loss or duplicate.
//  6. Mid-stream reset: assert rst_n=0 asynchronously while out_valid=1.
//     -> out_valid=0 immediately. After release, RR restarts at channel 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the registered arbitrating multiplexer.
//   MODE_FIXED / MODE_RR : values of the mode input
//   rr_next()            : round-robin pointer successor with wrap at nch-1
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Pointer moves to the channel after the winner, wrapping to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nch);
        return (idx == nch - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_arb_reg_if.sv
// Handshake bus between NCH producers, the mux, and one consumer.
//   in_valid / in_ready / in_data : producer side, channel i at bit i / [i*WIDTH +: WIDTH]
//   out_valid / out_ready         : consumer handshake
//   out_data / out_ch             : selected payload and its source channel
// The slave modport is the mux; the master modport is whoever drives producers and consumer.
interface mux_arb_reg_if #(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SELW  = $clog2(NCH)
);

    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational grant logic: fixed select or round-robin scan starting at ptr.
//   req_i        : per-channel requests
//   ptr_i        : highest-priority channel in RR mode
//   mode_i       : MODE_FIXED uses sel_i, MODE_RR scans from ptr_i
//   sel_i        : channel index in FIXED mode (>= NCH grants nothing)
//   gnt_onehot_o : one-hot grant, all zero when nothing is granted
//   gnt_idx_o    : granted channel index (0 when no grant)
//   gnt_vld_o    : a grant exists this cycle
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int unsigned NCH  = 4,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            mode_i,
    input  logic [SELW-1:0] sel_i,
    output logic [NCH-1:0]  gnt_onehot_o,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            gnt_vld_o
);

    // Request/grant vectors padded to the full select range so an
    // out-of-range sel simply reads a zero request.
    localparam int unsigned NPAD = 1 << SELW;

    logic [NPAD-1:0] req_pad;
    logic [NPAD-1:0] oh_pad;
    logic [SELW-1:0] cand;

    always_comb begin
        req_pad      = '0;
        oh_pad       = '0;
        cand         = '0;
        gnt_idx_o    = '0;
        gnt_vld_o    = 1'b0;
        req_pad[NCH-1:0] = req_i;

        if (mode_i == MODE_FIXED) begin
            if (req_pad[sel_i]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = sel_i;
            end
        end else begin
            // First requester at or after ptr, modulo NCH.
            for (int unsigned k = 0; k < NCH; k++) begin
                cand = SELW'((32'(ptr_i) + k) % NCH);
                if (!gnt_vld_o && req_pad[cand]) begin
                    gnt_vld_o = 1'b1;
                    gnt_idx_o = cand;
                end
            end
        end

        oh_pad[gnt_idx_o] = gnt_vld_o;
        gnt_onehot_o      = oh_pad[NCH-1:0];
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel registered multiplexer with valid/ready handshake and
// fixed-select or round-robin channel choice.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : MODE_FIXED (use sel) or MODE_RR (round-robin)
//   sel        : channel index in FIXED mode
//   bus        : producer/consumer handshake bus (slave side)
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    mux_arb_reg_if.slave    bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [NCH-1:0]   gnt_onehot;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req_i        (bus.in_valid),
        .ptr_i        (ptr_q),
        .mode_i       (mode),
        .sel_i        (sel),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .gnt_vld_o    (gnt_vld)
    );

    // Output register is free when empty or being drained this cycle.
    assign can_load = !out_valid_q || bus.out_ready;
    assign xfer     = can_load && gnt_vld;
    assign gnt_data = bus.in_data[32'(gnt_idx) * WIDTH +: WIDTH];

    // Ready is held low during reset so nothing is accepted into a register being cleared.
    assign bus.in_ready = (rst_n && xfer) ? gnt_onehot : '0;

    // Next-state for output register and RR pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;

        if (can_load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt_idx;
            end
        end

        if (xfer && (mode == MODE_RR)) begin
            ptr_d = SELW'(rr_next(32'(gnt_idx), NCH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
